// File: rtl/icache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W      = 10;
  localparam int NUM_SETS    = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int IDX_W       = $clog2(NUM_SETS);
  localparam int OFF_W       = $clog2(BLOCK_WORDS);
  localparam int TAG_W       = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int BLOCK_W     = 32 * BLOCK_WORDS;
  localparam int BADDR_W     = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_index(input logic [31:0] addr);
    return addr[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] get_offset(input logic [31:0] addr);
    return addr[2 +: OFF_W];
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Refill controller: IDLE -> MEM_READ -> UPDATE sequencing, block-address latch and
// the line write enable used by the top-level arrays.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hit,
  input  logic [BADDR_W-1:0] i_blk_addr,
  input  logic               i_mem_busywait,
  output logic               o_mem_read,
  output logic [BADDR_W-1:0] o_mem_address,
  output logic               o_busy,
  output logic               o_refill_we
);

  state_t             r_state;
  state_t             w_next;
  logic [BADDR_W-1:0] r_mem_address;

  // State register; reset abandons any in-flight refill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Block address is captured only on the miss decision so it stays stable through the refill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_address <= {BADDR_W{1'b0}};
    end else if ((r_state == S_IDLE) && !i_hit) begin
      r_mem_address <= i_blk_addr;
    end else begin
      r_mem_address <= r_mem_address;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!i_hit) begin
          w_next = S_MEM_READ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MEM_READ: begin
        if (!i_mem_busywait) begin
          w_next = S_UPDATE;
        end else begin
          w_next = S_MEM_READ;
        end
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_mem_read    = (r_state == S_MEM_READ);
  assign o_refill_we   = (r_state == S_UPDATE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_mem_address = r_mem_address;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: tag/valid/data arrays, combinational hit
// and word select, with block refills sequenced by icache_ctrl.
module instruction_cache
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        PC_ADDR,
  output logic [31:0]        INSTRUCTION,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic [BADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [BLOCK_W-1:0]  r_data [NUM_SETS];

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [OFF_W-1:0]    w_off;
  logic                w_hit;
  logic                w_busy;
  logic                w_refill_we;
  logic [TAG_W-1:0]    w_fill_tag;
  logic [IDX_W-1:0]    w_fill_idx;
  logic [BLOCK_W-1:0]  w_block;
  logic [31:0]         w_instr;

  assign w_tag   = get_tag(PC_ADDR);
  assign w_idx   = get_index(PC_ADDR);
  assign w_off   = get_offset(PC_ADDR);
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_block = r_data[w_idx];

  // The fill targets the latched block address, not the live PC, in case the PC moved mid-refill.
  assign w_fill_tag = MEM_ADDRESS[BADDR_W-1 -: TAG_W];
  assign w_fill_idx = MEM_ADDRESS[IDX_W-1:0];

  icache_ctrl u_ctrl (
    .i_clk          (CLK),
    .i_rst          (RESET),
    .i_hit          (w_hit),
    .i_blk_addr     ({w_tag, w_idx}),
    .i_mem_busywait (MEM_BUSYWAIT),
    .o_mem_read     (MEM_READ),
    .o_mem_address  (MEM_ADDRESS),
    .o_busy         (w_busy),
    .o_refill_we    (w_refill_we)
  );

  // Valid bits are the only storage cleared by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= {NUM_SETS{1'b0}};
    end else if (w_refill_we) begin
      r_valid[w_fill_idx] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Tag and data arrays, written once per refill.
  always_ff @(posedge CLK) begin
    if (w_refill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= MEM_READDATA;
    end
  end

  // Word select within the addressed line.
  always_comb begin
    w_instr = 32'h0000_0000;
    if (w_hit) begin
      w_instr = w_block[{w_off, 5'b00000} +: 32];
    end else begin
      w_instr = 32'h0000_0000;
    end
  end

  assign INSTRUCTION = w_instr;
  assign BUSYWAIT    = RESET ? 1'b0 : (w_busy || !w_hit);

endmodule
